// File: rtl/mod_addsub_pipe.sv
// mod_addsub_pipe
//   Multi-lane, two-stage pipelined modular adder/subtractor for the Kyber
//   coefficient datapath. Every beat carries LANES coefficient pairs and one
//   opcode that applies to all lanes. Results are reduced into [0, Q-1] and
//   appear two advancing cycles after the beat is accepted.
//
//   S1 forms the raw sum/difference on DWIDTH+1 bits. It also records the
//   per-lane borrow and whether any operand was out of range. S2 applies one
//   conditional +/-Q correction. Both stages advance together on a single
//   enable, which gives full-rate throughput with complete backpressure.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset; flushes both stages
//   in_valid   input beat valid
//   in_ready   block accepts a beat this cycle (= ~out_valid | out_ready)
//   in_op      0: (a+b) mod Q, 1: (a-b) mod Q
//   in_a/in_b  packed operands; lane i = bits [i*DWIDTH +: DWIDTH]
//   out_valid  result beat valid
//   out_ready  consumer accepts the result beat
//   out_res    packed reduced results, same packing as the operands
//   out_err    at least one operand >= Q in some lane of this beat
module mod_addsub_pipe #(
   parameter int DWIDTH = 12,
   parameter int Q      = 3329,
   parameter int LANES  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_op,
   input  logic [LANES*DWIDTH-1:0]   in_a,
   input  logic [LANES*DWIDTH-1:0]   in_b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*DWIDTH-1:0]   out_res,
   output logic                      out_err
);

   localparam int RW = DWIDTH + 1;
   localparam logic [RW-1:0]     Q_EXT = RW'(Q);
   localparam logic [DWIDTH-1:0] Q_D   = DWIDTH'(Q);

   // Stage 1: raw arithmetic results
   logic                    s1_valid_reg;
   logic                    s1_op_reg;
   logic                    s1_err_reg;
   logic [LANES*RW-1:0]     s1_raw_reg;
   logic [LANES-1:0]        s1_borrow_reg;

   // Stage 2: corrected results, which drive the outputs directly
   logic                    s2_valid_reg;
   logic                    s2_err_reg;
   logic [LANES*DWIDTH-1:0] s2_res_reg;

   logic [LANES*RW-1:0]     raw_next;
   logic [LANES-1:0]        borrow_next;
   logic [LANES-1:0]        lane_err;
   logic [LANES*DWIDTH-1:0] res_next;
   logic                    adv;

   // The whole pipe moves together. An empty or draining output slot frees
   // every stage.
   assign adv      = ~s2_valid_reg | out_ready;
   assign in_ready = adv;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [RW-1:0]     a_ext;
         logic [RW-1:0]     b_ext;
         logic [RW-1:0]     raw;
         logic [DWIDTH-1:0] raw_lo;

         assign a_ext = {1'b0, in_a[gi*DWIDTH +: DWIDTH]};
         assign b_ext = {1'b0, in_b[gi*DWIDTH +: DWIDTH]};

         // The extra bit holds the add carry. On a borrow it holds the wrapped
         // difference, which S2 fixes by adding Q modulo 2^DWIDTH.
         assign raw_next[gi*RW +: RW] = in_op ? (a_ext - b_ext) : (a_ext + b_ext);
         assign borrow_next[gi]       = a_ext < b_ext;
         assign lane_err[gi]          = (a_ext >= Q_EXT) | (b_ext >= Q_EXT);

         assign raw    = s1_raw_reg[gi*RW +: RW];
         assign raw_lo = raw[DWIDTH-1:0];

         // Both corrections are exact modulo 2^DWIDTH, so they only need the
         // low DWIDTH bits. The full-width raw value is used only to decide
         // whether the add needs a subtraction of Q.
         always_comb begin
            res_next[gi*DWIDTH +: DWIDTH] = raw_lo;
            if (s1_op_reg) begin
               if (s1_borrow_reg[gi])
                  res_next[gi*DWIDTH +: DWIDTH] = raw_lo + Q_D;
            end else begin
               if (raw >= Q_EXT)
                  res_next[gi*DWIDTH +: DWIDTH] = raw_lo - Q_D;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_reg  <= 1'b0;
         s1_op_reg     <= 1'b0;
         s1_err_reg    <= 1'b0;
         s1_raw_reg    <= '0;
         s1_borrow_reg <= '0;
         s2_valid_reg  <= 1'b0;
         s2_err_reg    <= 1'b0;
         s2_res_reg    <= '0;
      end else if (adv) begin
         s1_valid_reg  <= in_valid;
         s1_op_reg     <= in_op;
         // Gating with in_valid keeps bubbles from carrying a stray error flag.
         s1_err_reg    <= in_valid & (|lane_err);
         s1_raw_reg    <= raw_next;
         s1_borrow_reg <= borrow_next;
         s2_valid_reg  <= s1_valid_reg;
         s2_err_reg    <= s1_err_reg;
         s2_res_reg    <= res_next;
      end
   end

   assign out_valid = s2_valid_reg;
   assign out_res   = s2_res_reg;
   assign out_err   = s2_err_reg;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
module tb_mod_addsub_pipe;

   localparam int DW = 12;
   localparam int QM = 3329;
   localparam int NL = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          in_op = 1'b0;
   logic [95:0]   in_a = '0;
   logic [95:0]   in_b = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [95:0]   out_res;
   logic          out_err;

   int total = 0;
   int bad   = 0;
   int n_deliv = 0;

   typedef struct packed {
      logic [95:0] res;
      logic        err;
   } exp_t;
   exp_t exp_q[$];

   mod_addsub_pipe #(.DWIDTH(DW), .Q(QM), .LANES(NL)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res), .out_err(out_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [95:0] pk(input int l0, l1, l2, l3, l4, l5, l6, l7);
      return {12'(l7), 12'(l6), 12'(l5), 12'(l4), 12'(l3), 12'(l2), 12'(l1), 12'(l0)};
   endfunction

   // Reference: modular arithmetic on integers. Only the add path is used
   // with out-of-range operands, where a single subtraction of Q applies.
   function automatic logic [95:0] gold(input logic [95:0] a, b, input logic op);
      logic [95:0] r;
      int s;
      r = '0;
      for (int i = 0; i < NL; i++) begin
         if (!op) begin
            s = int'(a[i*DW +: DW]) + int'(b[i*DW +: DW]);
            if (s >= QM) s -= QM;
         end else begin
            s = int'(a[i*DW +: DW]) - int'(b[i*DW +: DW]);
            if (s < 0) s += QM;
         end
         r[i*DW +: DW] = 12'(s);
      end
      return r;
   endfunction

   function automatic logic gold_err(input logic [95:0] a, b);
      logic e;
      e = 1'b0;
      for (int i = 0; i < NL; i++)
         if (a[i*DW +: DW] >= 12'(QM) || b[i*DW +: DW] >= 12'(QM)) e = 1'b1;
      return e;
   endfunction

   function automatic logic [95:0] rnd_vec();
      logic [95:0] v;
      for (int i = 0; i < NL; i++) v[i*DW +: DW] = 12'($urandom_range(0, QM - 1));
      return v;
   endfunction

   // Scoreboard and handshake monitor. It samples mid-cycle, where inputs
   // and registered outputs are stable.
   logic        stall_prev = 1'b0;
   logic [95:0] held_res   = '0;
   logic        held_err   = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         stall_prev = 1'b0;
      end else begin
         chk("in_ready_rule", {95'd0, in_ready}, {95'd0, (~out_valid | out_ready)});
         if (stall_prev && out_valid) begin
            chk("stall_res_hold", out_res, held_res);
            chk("stall_err_hold", {95'd0, out_err}, {95'd0, held_err});
         end
         if (out_valid && out_ready) begin
            n_deliv++;
            if (exp_q.size() == 0) begin
               chk("unexpected_delivery", {95'd0, out_valid}, 96'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("sb_res", out_res, e.res);
               chk("sb_err", {95'd0, out_err}, {95'd0, e.err});
            end
         end
         if (in_valid && in_ready)
            exp_q.push_back('{res: gold(in_a, in_b, in_op), err: gold_err(in_a, in_b)});
         stall_prev = out_valid & ~out_ready;
         held_res   = out_res;
         held_err   = out_err;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int idx;
      int d0;
      logic [95:0] va[5];
      logic [95:0] vb[5];

      // Reset state
      #12;
      chk("rst_out_valid", {95'd0, out_valid}, 96'd0);
      chk("rst_in_ready", {95'd0, in_ready}, 96'd1);
      chk("rst_out_res", out_res, 96'd0);
      chk("rst_out_err", {95'd0, out_err}, 96'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Add wrap
      in_valid = 1'b1; in_op = 1'b0;
      in_a = pk(3328, 1664, 1000, 0, 0, 0, 0, 0);
      in_b = pk(1, 1665, 2000, 0, 0, 0, 0, 0);
      tick();
      in_valid = 1'b0;
      chk("add_lat1_valid", {95'd0, out_valid}, 96'd0);
      tick();
      chk("add_valid", {95'd0, out_valid}, 96'd1);
      chk("add_res", out_res, pk(0, 0, 3000, 0, 0, 0, 0, 0));
      chk("add_err", {95'd0, out_err}, 96'd0);
      tick();
      chk("add_drained", {95'd0, out_valid}, 96'd0);

      // Sub borrow
      in_valid = 1'b1; in_op = 1'b1;
      in_a = pk(0, 5, 3328, 100, 0, 0, 0, 0);
      in_b = pk(1, 5, 0, 3328, 0, 0, 0, 0);
      tick();
      in_valid = 1'b0;
      tick();
      chk("sub_valid", {95'd0, out_valid}, 96'd1);
      chk("sub_res", out_res, pk(3328, 0, 3328, 101, 0, 0, 0, 0));
      chk("sub_err", {95'd0, out_err}, 96'd0);
      tick();

      // Error flag on one beat only
      in_valid = 1'b1; in_op = 1'b0;
      in_a = pk(1, 2, 3, 4, 5, 3329, 7, 8);
      in_b = pk(1, 1, 1, 1, 1, 0, 1, 1);
      tick();
      in_a = pk(10, 20, 30, 40, 50, 60, 70, 80);
      in_b = pk(3300, 3300, 0, 0, 0, 0, 0, 0);
      tick();
      in_valid = 1'b0;
      chk("err_first", {95'd0, out_err}, 96'd1);
      chk("err_first_res", out_res, pk(2, 3, 4, 5, 6, 0, 8, 9));
      tick();
      chk("err_second", {95'd0, out_err}, 96'd0);
      chk("err_second_res", out_res, pk(3310, 3320, 30, 40, 50, 60, 70, 80));
      tick();

      // Backpressure: five beats, alternating op, consumer stalls cycles 3..6
      for (int i = 0; i < 5; i++) begin
         va[i] = rnd_vec();
         vb[i] = rnd_vec();
      end
      d0 = n_deliv;
      idx = 0;
      for (int c = 0; c < 20; c++) begin
         out_ready = !(c >= 3 && c <= 6);
         in_valid  = (idx < 5);
         if (idx < 5) begin
            in_a = va[idx]; in_b = vb[idx]; in_op = idx[0];
         end
         if (c >= 4 && c <= 6)
            chk("bp_in_ready_low", {95'd0, in_ready}, 96'd0);
         if (in_valid && in_ready) idx++;
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk("bp_accepted", 96'(idx), 96'd5);
      chk("bp_delivered", 96'(n_deliv - d0), 96'd5);
      chk("bp_queue_empty", 96'(exp_q.size()), 96'd0);

      // Full rate
      d0 = n_deliv;
      in_valid = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         in_a = rnd_vec(); in_b = rnd_vec(); in_op = 1'($urandom_range(0, 1));
         tick();
      end
      in_valid = 1'b0;
      chk("fr_during", 96'(n_deliv - d0), 96'd998);
      tick(); tick(); tick();
      chk("fr_total", 96'(n_deliv - d0), 96'd1000);

      // Async reset with two beats in flight and the consumer stalled
      in_valid = 1'b1; in_op = 1'b0;
      in_a = pk(1, 1, 1, 1, 1, 1, 1, 1); in_b = pk(2, 2, 2, 2, 2, 2, 2, 2);
      tick();
      in_a = pk(3, 3, 3, 3, 3, 3, 3, 3);
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      tick();
      chk("ar_pre_valid", {95'd0, out_valid}, 96'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_out_valid", {95'd0, out_valid}, 96'd0);
      chk("ar_out_res", out_res, 96'd0);
      chk("ar_out_err", {95'd0, out_err}, 96'd0);
      chk("ar_in_ready", {95'd0, in_ready}, 96'd1);
      tick();
      rst = 1'b0; out_ready = 1'b1;
      tick(); tick(); tick();
      chk("ar_no_stale", {95'd0, out_valid}, 96'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
